// File: rtl/pattern_checker_v2.sv
// Data-pattern checker: hunts for lock on inc/dec/walking-one streams, then free-runs and counts errors.
// Optional on-chip loopback generator enabled by defining PATTERN_CHECKER_GEN_EN.
module pattern_checker_v2 #(
  parameter int WIDTH      = 8,
  parameter int STEP       = 1,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clkin,
  input  logic             rstin,
  input  logic [1:0]       mode,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             locked,
  output logic             match,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
`ifdef PATTERN_CHECKER_GEN_EN
  ,
  input  logic             gen_en,
  output logic [WIDTH-1:0] gen_data
`endif
);

  localparam int HIT_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(LOSS_COUNT + 1);
  localparam logic [WIDTH-1:0]  STEP_V = WIDTH'(STEP);
  localparam logic [HIT_W-1:0]  LOCK_V = HIT_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0] LOSS_V = MISS_W'(LOSS_COUNT);

  typedef enum logic [1:0] {
    S_HUNT   = 2'b00,
    S_TRACK  = 2'b01,
    S_LOCKED = 2'b10
  } state_t;

  function automatic logic [WIDTH-1:0] f_next(input logic [1:0] m, input logic [WIDTH-1:0] x);
    case (m)
      2'b01:   return x - STEP_V;
      2'b10:   return {x[WIDTH-2:0], x[WIDTH-1]};
      default: return x + STEP_V;
    endcase
  endfunction

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_mode;
  logic [WIDTH-1:0]   r_expected, w_expected_nxt;
  logic               r_match, w_match_nxt;
  logic               r_locked, w_locked_nxt;
  logic [CNT_W-1:0]   r_err, w_err_nxt;
  logic [HIT_W-1:0]   r_hit, w_hit_nxt, w_hit_inc;
  logic [MISS_W-1:0]  r_miss, w_miss_nxt, w_miss_inc;
  logic [1:0]         w_mode_n;
  logic               w_mode_chg;

  // Mode 11 aliases increment, so it is folded before comparison with the registered mode.
  assign w_mode_n   = (mode == 2'b11) ? 2'b00 : mode;
  assign w_mode_chg = (w_mode_n != r_mode);
  assign w_hit_inc  = r_hit + HIT_W'(1);
  assign w_miss_inc = r_miss + MISS_W'(1);

  // Next-state and next-output logic for the hunt/track/locked machine.
  always_comb begin
    w_state_nxt    = r_state;
    w_expected_nxt = r_expected;
    w_match_nxt    = r_match;
    w_locked_nxt   = r_locked;
    w_err_nxt      = r_err;
    w_hit_nxt      = r_hit;
    w_miss_nxt     = r_miss;
    if (clear) begin
      w_state_nxt  = S_HUNT;
      w_match_nxt  = 1'b0;
      w_locked_nxt = 1'b0;
      w_err_nxt    = {CNT_W{1'b0}};
      w_hit_nxt    = {HIT_W{1'b0}};
      w_miss_nxt   = {MISS_W{1'b0}};
    end else if (w_mode_chg) begin
      w_state_nxt  = S_HUNT;
      w_match_nxt  = 1'b0;
      w_locked_nxt = 1'b0;
      w_hit_nxt    = {HIT_W{1'b0}};
      w_miss_nxt   = {MISS_W{1'b0}};
    end else if (din_valid) begin
      case (r_state)
        S_HUNT: begin
          w_expected_nxt = f_next(r_mode, din);
          w_hit_nxt      = {HIT_W{1'b0}};
          w_match_nxt    = 1'b0;
          w_state_nxt    = S_TRACK;
        end
        S_TRACK: begin
          if (din == r_expected) begin
            w_match_nxt    = 1'b1;
            w_expected_nxt = f_next(r_mode, r_expected);
            if (w_hit_inc == LOCK_V) begin
              w_state_nxt  = S_LOCKED;
              w_locked_nxt = 1'b1;
              w_hit_nxt    = {HIT_W{1'b0}};
            end else begin
              w_hit_nxt    = w_hit_inc;
            end
          end else begin
            w_match_nxt    = 1'b0;
            w_expected_nxt = f_next(r_mode, din);
            w_hit_nxt      = {HIT_W{1'b0}};
          end
        end
        S_LOCKED: begin
          // Prediction free-runs so an isolated corrupt word never re-aligns the tracker.
          w_expected_nxt = f_next(r_mode, r_expected);
          if (din == r_expected) begin
            w_match_nxt = 1'b1;
            w_miss_nxt  = {MISS_W{1'b0}};
          end else begin
            w_match_nxt = 1'b0;
            w_err_nxt   = (r_err == {CNT_W{1'b1}}) ? r_err : r_err + CNT_W'(1);
            if (w_miss_inc == LOSS_V) begin
              w_state_nxt  = S_HUNT;
              w_locked_nxt = 1'b0;
              w_miss_nxt   = {MISS_W{1'b0}};
            end else begin
              w_miss_nxt   = w_miss_inc;
            end
          end
        end
        default: begin
          w_state_nxt  = S_HUNT;
          w_locked_nxt = 1'b0;
          w_match_nxt  = 1'b0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State and output registers.
  always_ff @(posedge clkin or negedge rstin) begin
    if (!rstin) begin
      r_state    <= S_HUNT;
      r_mode     <= 2'b00;
      r_expected <= {WIDTH{1'b0}};
      r_match    <= 1'b0;
      r_locked   <= 1'b0;
      r_err      <= {CNT_W{1'b0}};
      r_hit      <= {HIT_W{1'b0}};
      r_miss     <= {MISS_W{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_mode     <= w_mode_n;
      r_expected <= w_expected_nxt;
      r_match    <= w_match_nxt;
      r_locked   <= w_locked_nxt;
      r_err      <= w_err_nxt;
      r_hit      <= w_hit_nxt;
      r_miss     <= w_miss_nxt;
    end
  end

  assign locked    = r_locked;
  assign match     = r_match;
  assign err_count = r_err;
  assign expected  = r_expected;

`ifdef PATTERN_CHECKER_GEN_EN
  logic [WIDTH-1:0] r_gen;
  logic [WIDTH-1:0] w_gen_seed;

  assign w_gen_seed = (w_mode_n == 2'b10) ? WIDTH'(1) : {WIDTH{1'b0}};

  // Loopback source; registered mode resets to increment, hence a zero seed at reset.
  always_ff @(posedge clkin or negedge rstin) begin
    if (!rstin) begin
      r_gen <= {WIDTH{1'b0}};
    end else if (clear || w_mode_chg) begin
      r_gen <= w_gen_seed;
    end else if (gen_en) begin
      r_gen <= f_next(w_mode_n, r_gen);
    end else begin
      r_gen <= r_gen;
    end
  end

  assign gen_data = r_gen;
`else
  // Checker-only build: no generator.
`endif

endmodule

// File: tb/tb_pattern_checker_v2.sv
// Scoreboard bench for pattern_checker_v2: directed bring-up sequences followed by randomized streams,
// checked against a behavioural model of the lock/track/error rules.
module tb_pattern_checker_v2;
  localparam int W    = 8;
  localparam int STEP = 3;
  localparam int LC   = 4;
  localparam int LS   = 3;
  localparam int CW   = 4;

  logic          clkin = 1'b0;
  logic          rstin;
  logic [1:0]    mode;
  logic          clear;
  logic [W-1:0]  din;
  logic          din_valid;
  logic          locked;
  logic          match;
  logic [CW-1:0] err_count;
  logic [W-1:0]  expected;

  pattern_checker_v2 #(
    .WIDTH(W), .STEP(STEP), .LOCK_COUNT(LC), .LOSS_COUNT(LS), .CNT_W(CW)
  ) dut (
    .clkin(clkin), .rstin(rstin), .mode(mode), .clear(clear), .din(din),
    .din_valid(din_valid), .locked(locked), .match(match),
    .err_count(err_count), .expected(expected)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    bit locked;
    bit match;
    int err;
    bit chk_exp;
    int exp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_seeded, m_locked, m_match;
  int m_pred, m_err, m_hit, m_miss, m_mode;

  // Stimulus source state
  int src, cur_mode, burst;

  function automatic int nx(int m, int x);
    if (m == 1) return ((x - STEP) % 256 + 256) % 256;
    if (m == 2) return ((x * 2) % 256) + (x / 128);
    return (x + STEP) % 256;
  endfunction

  function automatic int norm(int m);
    return (m == 3) ? 0 : m;
  endfunction

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_seeded = 0; m_locked = 0; m_match = 0;
    m_pred = 0; m_err = 0; m_hit = 0; m_miss = 0; m_mode = 0;
  endtask

  task automatic model_step(bit v, int d, int md, bit clr);
    int  mn;
    bit  ok;
    mn = norm(md);
    if (clr) begin
      m_seeded = 0; m_locked = 0; m_match = 0; m_err = 0; m_hit = 0; m_miss = 0;
    end else if (mn != m_mode) begin
      m_seeded = 0; m_locked = 0; m_match = 0; m_hit = 0; m_miss = 0;
    end else if (v) begin
      if (!m_seeded) begin
        m_pred = nx(m_mode, d); m_hit = 0; m_seeded = 1; m_match = 0;
      end else if (!m_locked) begin
        if (d == m_pred) begin
          m_match = 1; m_pred = nx(m_mode, m_pred); m_hit++;
          if (m_hit == LC) begin m_locked = 1; m_hit = 0; end
        end else begin
          m_match = 0; m_pred = nx(m_mode, d); m_hit = 0;
        end
      end else begin
        ok = (d == m_pred);
        m_pred = nx(m_mode, m_pred);
        if (ok) begin
          m_match = 1; m_miss = 0;
        end else begin
          m_match = 0;
          if (m_err < (1 << CW) - 1) m_err++;
          m_miss++;
          if (m_miss == LS) begin m_locked = 0; m_seeded = 0; m_miss = 0; end
        end
      end
    end
    m_mode = mn;
  endtask

  // Drive one cycle of inputs and record what the DUT must show after the next edge.
  task automatic beat(bit v, int d, int md, bit clr);
    @(negedge clkin);
    din_valid = v; din = W'(d); mode = 2'(md); clear = clr;
    model_step(v, d, md, clr);
    sb.push_back('{m_locked, m_match, m_err, m_seeded, m_pred});
  endtask

  task automatic after_edge();
    @(posedge clkin);
    #2;
  endtask

  task automatic gen_beat();
    bit v;
    int d;
    bit clr;
    clr = 0;
    if ($urandom_range(0, 199) == 0) begin
      cur_mode = $urandom_range(0, 3);
      src = (cur_mode == 2) ? (1 << $urandom_range(0, 7)) : $urandom_range(0, 255);
    end
    if ($urandom_range(0, 249) == 0) clr = 1;
    v = ($urandom_range(0, 9) < 8);
    d = src;
    if (v) begin
      if (burst > 0) begin
        d = src ^ (1 + $urandom_range(0, 254)); burst--;
      end else if ($urandom_range(0, 11) == 0) begin
        d = $urandom_range(0, 255);
      end else if ($urandom_range(0, 59) == 0) begin
        d = src ^ (1 + $urandom_range(0, 254)); burst = 2;
      end
      src = nx(norm(cur_mode), src);
    end
    beat(v, d, cur_mode, clr);
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_match"}, match, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_expected"}, expected, 0);
  endtask

  // Monitor: compare DUT outputs with the scoreboard after every active edge.
  always @(posedge clkin) begin
    #1;
    if (rstin === 1'b1 && sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("locked", locked, mon_e.locked);
      chk("match", match, mon_e.match);
      chk("err_count", err_count, mon_e.err);
      if (mon_e.chk_exp) chk("expected", expected, mon_e.exp);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    int g, w, s;
    rstin = 1'b0; clear = 1'b0; din_valid = 1'b0; din = '0; mode = 2'b00;
    model_reset();
    burst = 0;
    #12;
    check_reset_values("reset");
    @(negedge clkin);
    rstin = 1'b1;

    // Increment by STEP from 0: lock on the beat carrying 4*STEP.
    for (int k = 0; k < 5; k++) beat(1, (k * STEP) % 256, 0, 0);
    after_edge();
    chk("lock_after_seed_plus_4", locked, 1);
    for (int k = 5; k < 14; k++) beat(1, (k == 10) ? 8'h55 : (k * STEP) % 256, 0, 0);
    for (int k = 0; k < 3; k++) beat(1, 0, 0, 0);
    after_edge();
    chk("lock_lost_after_3_miss", locked, 0);
    chk("err_after_loss", err_count, 4);
    for (int k = 17; k < 22; k++) beat(1, (k * STEP) % 256, 0, 0);
    after_edge();
    chk("relock", locked, 1);

    // Decrement across zero, then walking-one with MSB wrap.
    beat(1, 8, 1, 0);
    after_edge();
    chk("mode_change_unlocks", locked, 0);
    chk("mode_change_keeps_err", err_count, 4);
    g = 8;
    for (int k = 0; k < 10; k++) begin beat(1, g, 1, 0); g = nx(1, g); end
    beat(1, 1, 2, 0);
    w = 1;
    for (int k = 0; k < 11; k++) begin beat(1, w, 2, 0); w = nx(2, w); end
    beat(1, 0, 0, 0);

    // Saturate the error counter with repeated lock/lose cycles.
    beat(1, 0, 0, 1);
    s = 0;
    for (int r = 0; r < 7; r++) begin
      for (int k = 0; k < 5; k++) begin beat(1, s, 0, 0); s = nx(0, s); end
      for (int k = 0; k < 3; k++) begin beat(1, s ^ 8'hA5, 0, 0); s = nx(0, s); end
    end
    after_edge();
    chk("err_saturated", err_count, 15);
    beat(1, s, 0, 1);
    after_edge();
    chk("clear_err", err_count, 0);

    // Randomized streams with a reset in the middle.
    src = 0; cur_mode = 0;
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) begin
        @(negedge clkin);
        rstin = 1'b0;
        din_valid = 1'b0; clear = 1'b0; mode = 2'b00;
        #2;
        check_reset_values("midreset");
        model_reset();
        @(negedge clkin);
        rstin = 1'b1;
        cur_mode = 0; src = $urandom_range(0, 255); burst = 0;
      end
      gen_beat();
    end
    @(negedge clkin);
    din_valid = 1'b0;
    @(negedge clkin);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pattern_checker_v2.md
Name: pattern_checker_v2

Overview:
- Synthesizable, parametrised data-pattern checker for capture-path bring-up. Replaces the bench-only "outdata == previous + 1" comparator.
- Sits after the capture/DCM stage in the clkin domain. Hunts for lock on an incoming word stream, then tracks it free-running.
- Reports lock status, a per-beat match flag and a saturating error count.
- Supports increment-by-STEP, decrement-by-STEP and walking-one patterns at any width.

Parameters:
- WIDTH, 8, data word width in bits (>= 2).
- STEP, 1, increment/decrement step; applied modulo 2^WIDTH.
- LOCK_COUNT, 4, consecutive correct predictions needed to declare lock (>= 1).
- LOSS_COUNT, 3, consecutive mismatches while locked that drop lock (>= 1).
- CNT_W, 16, error counter width.

Ports:
- clkin  in  1  system clock; all logic on rising edge.
- rstin  in  1  asynchronous, active-low reset.
- mode  in  2  00 increment, 01 decrement, 10 walking-one rotate left, 11 treated as 00.
- clear  in  1  synchronous clear of err_count and state.
- din  in  WIDTH  captured data word.
- din_valid  in  1  din is a new beat this cycle.
- locked  out  1  checker is in LOCKED.
- match  out  1  result of the last valid beat's comparison.
- err_count  out  CNT_W  mismatches counted while LOCKED, saturating.
- expected  out  WIDTH  current prediction for the next valid beat.

Behaviour:
- Reset (rstin low, asynchronous): state=HUNT, locked=0, match=0, err_count=0, expected=0, run counters=0, mode register=00.
- next(x) by mode:
  - inc: x+STEP mod 2^WIDTH.
  - dec: x-STEP mod 2^WIDTH.
  - walk: rotate-left by 1 (MSB to bit0). next(0)=0.
- Only cycles with din_valid=1 advance the state, counters or match. With din_valid=0, everything holds.
- HUNT:
  - First valid beat: expected<=next(din), hit_run<=0, go TRACK. match stays 0.
- TRACK:
  - Valid beat with din==expected: match<=1, expected<=next(expected), hit_run+1.
  - When hit_run+1 == LOCK_COUNT: go LOCKED, locked=1 on the same clock edge.
  - Valid beat with din!=expected: match<=0, reseed expected<=next(din), hit_run<=0, stay TRACK.
- LOCKED:
  - expected free-runs as next(expected) on every valid beat, regardless of din. A single corrupt word causes no re-alignment.
  - Match: match<=1, miss_run<=0.
  - Mismatch: match<=0, err_count+1 (saturates at all-ones, no wrap), miss_run+1.
  - When miss_run+1 == LOSS_COUNT: go HUNT, locked<=0, miss_run<=0. That final mismatch is still counted.
- Latency: match, locked and err_count are registered outputs, updated 1 clock after the valid beat is sampled.
- Wrap-around:
  - inc: expected all-ones followed by din=0 is a match.
  - dec: 0 followed by din=2^WIDTH-STEP is a match.
- Mode change: mode is registered internally. If the sampled mode differs from the registered mode, the next edge forces HUNT, clears locked, match and run counters, and keeps err_count. Valid data on that edge is ignored.
- clear=1: next edge forces HUNT with err_count=0, match=0, locked=0. clear takes priority over din_valid and over a mode change in the same cycle.
- Reset mid-stream: immediate asynchronous return to reset values. Re-lock needs 1 seed beat plus LOCK_COUNT correct beats after rstin deasserts.

Optional Feature:
- Macro PATTERN_CHECKER_GEN_EN.
- Defined: adds an on-chip generator with ports gen_en (in, 1) and gen_data (out, WIDTH).
  - gen_data resets to 1 in walking-one mode and 0 otherwise.
  - Advances by next() under the current mode on each clock with gen_en=1.
  - Holds when gen_en=0. Reloads its reset seed on a mode change or clear.
  - Allows loopback bring-up without an external source.
- Undefined: those ports and the generator logic are absent; checker behaviour is identical.

Test Plan:
- WIDTH=8, mode=00, din=0,1,2,... valid every cycle after rstin rises -> locked=1 on the clock edge that samples din=4 (seed 0, 4 correct predictions); match=1 from the din=1 beat; err_count=0.
- Locked incrementing stream, inject din=8'h55 once in place of 8'h20 -> match=0 for that beat only, err_count=1, locked stays 1, next beat 8'h21 gives match=1.
- Locked stream, replace 3 consecutive beats with 8'h00 -> err_count=3, locked=0 after the third beat, relock after 1+4 good beats.
- mode=00 stream wrapping 8'hFE,8'hFF,8'h00,8'h01 -> no mismatch, err_count unchanged. Repeat mode=01 with STEP=3 across 8'h02 to 8'hFF -> no mismatch.
- mode=10, din=01,02,04,...,80,01 -> locked after 5 beats, 80->01 counted as a match. Switch mode to 00 mid-stream -> locked=0 next edge, err_count kept. Assert clear -> err_count=0.
- CNT_W=4, force 20 errors while locked (LOSS_COUNT=255) -> err_count saturates at 4'hF. With PATTERN_CHECKER_GEN_EN, gen_data looped to din -> locked=1 and err_count=0 over 1000 beats.
